instruction_fetch: RTL and testbench

Fetch stage directly upstream of control_unit in the MIPS datapath. Holds the PC and requests instructions from instruction memory through a variable-latency req/ready handshake. Latches each returned word into an instruction register and drives op_instruction (instr[31:26]) to control_unit. Computes the next PC from the jump, branch and zero signals sampled when decode consumes the instruction.

---
 rtl/mips_pkg.sv | 17 +
 rtl/next_pc_logic.sv | 30 +++
 rtl/instruction_fetch.sv | 83 ++++++++
 tb/tb_instruction_fetch.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcodes, fetch FSM states and PC width.
package mips_pkg;

   localparam int PC_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic {
      FETCH,
      ISSUE
   } fetch_state_t;

endpackage

// File: rtl/next_pc_logic.sv
// Next-PC selection: jump over taken branch over sequential.
module next_pc_logic
   import mips_pkg::*;
(
   input  logic [PC_W-1:0] pc_plus4,
   input  logic [25:0]     target,
   input  logic [PC_W-1:0] branch_offset,
   input  logic            branch,
   input  logic            zero,
   input  logic            jump,
   output logic [PC_W-1:0] next_pc
);

   logic take_jump;
   logic take_br;

   assign take_jump = jump;
   assign take_br   = !jump && branch && zero;

   always_comb begin
      next_pc = pc_plus4;
      unique case (1'b1)
         take_jump: next_pc = {pc_plus4[31:28], target, 2'b00};
         take_br:   next_pc = pc_plus4 + (branch_offset << 2);
         default:   next_pc = pc_plus4;
      endcase
      next_pc[1:0] = 2'b00;
   end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, imem req/ready handshake, instruction register.
module instruction_fetch
   import mips_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [PC_W-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   input  logic            stall,
   input  logic            branch,
   input  logic            zero,
   input  logic            jump,
   input  logic [31:0]     branch_offset,
   output logic [31:0]     instr,
   output logic [5:0]      op_instruction,
   output logic [PC_W-1:0] pc_plus4,
   output logic            instr_valid
);

   fetch_state_t    state;
   fetch_state_t    next_state;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] next_pc;
   logic            capture;
   logic            consume;

   next_pc_logic u_next_pc (
      .pc_plus4      (pc_plus4),
      .target        (instr[25:0]),
      .branch_offset (branch_offset),
      .branch        (branch),
      .zero          (zero),
      .jump          (jump),
      .next_pc       (next_pc)
   );

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      consume    = 1'b0;
      unique case (state)
         FETCH: begin
            capture = imem_ready;
            if (imem_ready) next_state = ISSUE;
         end
         ISSUE: begin
            consume = !stall;
            if (!stall) next_state = FETCH;
         end
         default: next_state = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= FETCH;
      else        state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc       <= RESET_PC;
         instr    <= '0;
         pc_plus4 <= '0;
      end else begin
         if (capture) begin
            instr    <= imem_rdata;
            pc_plus4 <= pc + 32'd4;
         end
         if (consume) pc <= next_pc;
      end
   end

   // Gated by rst_n so nothing is requested or offered mid-reset.
   assign imem_req       = rst_n && (state == FETCH);
   assign instr_valid    = rst_n && (state == ISSUE);
   assign imem_addr      = pc;
   assign op_instruction = instr[31:26];

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboarded bench for instruction_fetch: directed plus random.
module tb_instruction_fetch;
   import mips_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic        stall;
   logic        branch;
   logic        zero;
   logic        jump;
   logic [31:0] branch_offset;
   logic [31:0] instr;
   logic [5:0]  op_instruction;
   logic [31:0] pc_plus4;
   logic        instr_valid;

   instruction_fetch #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ready     (imem_ready),
      .imem_rdata     (imem_rdata),
      .stall          (stall),
      .branch         (branch),
      .zero           (zero),
      .jump           (jump),
      .branch_offset  (branch_offset),
      .instr          (instr),
      .op_instruction (op_instruction),
      .pc_plus4       (pc_plus4),
      .instr_valid    (instr_valid)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [31:0] addr;
      logic        valid;
      logic [31:0] instr;
      logic [31:0] p4;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model: PC, captured word, its pc+4, waiting-for-decode flag
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_p4;
   logic        m_issue;

   task automatic chk(input string n, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("imem_req", {31'd0, imem_req}, {31'd0, e.req});
         chk("imem_addr", imem_addr, e.addr);
         chk("instr_valid", {31'd0, instr_valid}, {31'd0, e.valid});
         chk("instr", instr, e.instr);
         chk("op_instruction", {26'd0, op_instruction},
             {26'd0, e.instr[31:26]});
         chk("pc_plus4", pc_plus4, e.p4);
      end
   end

   task automatic step(input logic r, input logic rdy,
                       input logic [31:0] rd, input logic st,
                       input logic br, input logic z, input logic j,
                       input logic [31:0] off);
      exp_t e;
      logic [31:0] t;
      rst_n = r; imem_ready = rdy; imem_rdata = rd;
      stall = st; branch = br; zero = z; jump = j;
      branch_offset = off;
      if (!r) begin
         m_pc = RST_PC; m_instr = 0; m_p4 = 0; m_issue = 0;
      end else if (!m_issue) begin
         if (rdy) begin
            m_instr = rd; m_p4 = m_pc + 32'd4; m_issue = 1;
         end
      end else if (!st) begin
         if (j)
            t = (m_p4 & 32'hF000_0000) | ((m_instr & 32'h03FF_FFFF) * 4);
         else if (br && z)
            t = m_p4 + off * 4;
         else
            t = m_p4;
         m_pc = t & ~32'd3;
         m_issue = 0;
      end
      e.req = r && !m_issue;
      e.addr = m_pc;
      e.valid = r && m_issue;
      e.instr = m_instr;
      e.p4 = m_p4;
      exp_q.push_back(e);
      @(negedge clk);
      #2;
   endtask

   task automatic fetch(input logic [31:0] rd);
      step(1, 1, rd, 0, 0, 0, 0, 0);
   endtask

   task automatic consume(input logic br, input logic z, input logic j,
                          input logic [31:0] off);
      step(1, 0, 32'hDEAD_BEEF, 0, br, z, j, off);
   endtask

   localparam logic [31:0] W_LW  = 32'h8C08_0004;
   localparam logic [31:0] W_J4  = {OP_J, 26'h4};
   localparam logic [31:0] W_J10 = {OP_J, 26'h10};
   localparam logic [31:0] W_BEQ = {OP_BEQ, 10'd0, 16'hFFFE};
   localparam logic [31:0] W_R   = {OP_RTYPE, 26'h12_3456};

   initial begin
      logic [5:0]  ops [5];
      logic [15:0] o16;
      logic [31:0] rw;
      ops[0] = OP_RTYPE; ops[1] = OP_J; ops[2] = OP_BEQ;
      ops[3] = OP_LW; ops[4] = OP_SW;
      m_pc = RST_PC; m_instr = 0; m_p4 = 0; m_issue = 0;

      step(0, 1, W_SWAP(), 0, 0, 0, 0, 0);
      step(0, 1, W_LW, 0, 0, 0, 0, 0);
      chk("reset_instr", instr, 32'd0);
      chk("reset_req", {31'd0, imem_req}, 32'd0);

      fetch(W_LW);
      chk("first_op", {26'd0, op_instruction}, {26'd0, OP_LW});
      chk("first_p4", pc_plus4, 32'd4);
      consume(0, 0, 0, 0);
      chk("first_next", imem_addr, 32'd4);

      repeat (3) step(1, 0, 32'h0, 0, 0, 0, 0, 0);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
      fetch(W_R);
      repeat (2) step(1, 0, 32'h0, 1, 1, 1, 1, 32'h10);
      chk("stall_instr", instr, W_R);
      chk("stall_req", {31'd0, imem_req}, 32'd0);
      consume(0, 0, 0, 0);
      chk("stall_next", imem_addr, 32'd8);

      fetch(W_J4);
      consume(0, 0, 1, 0);
      chk("jump_to_10", imem_addr, 32'h10);
      fetch(W_BEQ);
      consume(1, 1, 0, 32'hFFFF_FFFE);
      chk("beq_taken", imem_addr, 32'h0C);
      fetch(W_J4);
      consume(0, 0, 1, 0);
      fetch(W_BEQ);
      consume(1, 0, 0, 32'hFFFF_FFFE);
      chk("beq_not_taken", imem_addr, 32'h14);

      fetch(W_R);
      consume(1, 1, 0, 32'h0FFF_FFFA);
      chk("br_far", imem_addr, 32'h4000_0000);
      fetch(W_J10);
      consume(1, 1, 1, 32'h0000_0100);
      chk("jump_prio", imem_addr, 32'h4000_0040);
      fetch(W_R);
      consume(1, 1, 0, 32'h2FFF_FFEE);
      chk("br_top", imem_addr, 32'hFFFF_FFFC);
      fetch(W_R);
      consume(0, 0, 0, 0);
      chk("pc_wrap", imem_addr, 32'h0);

      step(1, 0, 32'h0, 0, 0, 0, 0, 0);
      step(0, 1, W_LW, 0, 0, 0, 0, 0);
      chk("midrst_instr", instr, 32'd0);
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midrst_req", {31'd0, imem_req}, 32'd0);
      step(1, 0, 32'h0, 0, 0, 0, 0, 0);
      chk("midrst_addr", imem_addr, RST_PC);

      for (int i = 0; i < 1500; i++) begin
         o16 = 16'($urandom);
         rw = {ops[$urandom_range(0, 4)], 26'($urandom)};
         step($urandom_range(0, 63) != 0,
              $urandom_range(0, 2) == 0, rw,
              $urandom_range(0, 2) == 0,
              1'($urandom), 1'($urandom),
              $urandom_range(0, 3) == 0,
              {{16{o16[15]}}, o16});
      end

      @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   function automatic logic [31:0] W_SWAP();
      return {OP_SW, 26'h3FF_FFFF};
   endfunction

endmodule
